alu_mdu_seq: RTL and testbench
==============================

// Module: alu_mdu_seq
// PURPOSE
//  Parametrised successor to the single-cycle integer ALU. Adds iterative signed multiply, mulh, div and rem
//  behind a valid/ready handshake. Sits in EX: decode issues {op,is32,x,y}; result goes to writeback.
//  Simple ops take 1 cycle. Mul/div ops occupy a multi-cycle unit; EX stalls on in_ready=0.
// PARAMETERS
//  XLEN      64  datapath width (32 or 64); 32-bit mode (is32) is legal only when XLEN=64
//  OP_W      15  one-hot opcode width
//  MUL_ITER  1   1: radix-2 shift-add multiply (iterative); 0: single-cycle multiply via '*'
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      operation request
//  in_ready   out  1      unit can accept; transfer when in_valid & in_ready
//  op         in   OP_W   one-hot: 0 add,1 sub,2 and,3 or,4 xor,5 sll,6 srl,7 sra,8 mul,9 mulh,10 div,11 rem,12 slt,13 sltu,14 eq
//  is32       in   1      word op: use operand bits [31:0], sign-extend result bit 31 to XLEN
//  x, y       in   XLEN   operands
//  kill       in   1      abort the in-flight op (pipeline flush)
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer accepts result
//  result     out  XLEN   result, stable while out_valid=1
//  busy       out  1      state==BUSY
// BEHAVIOUR
//  Reset (async): state=IDLE, in_ready=1, out_valid=0, result=0, busy=0, iteration counter=0.
//  FSM IDLE -> accept: op in {mul(MUL_ITER=1),mulh,div,rem} and no div shortcut -> BUSY; otherwise -> DONE.
//      BUSY -> counter reaches N-1 -> DONE. DONE -> out_ready=1 -> IDLE. kill in any state -> IDLE next cycle, result discarded.
//  in_ready=1 only in IDLE. No accept in DONE, even when out_ready=1 in the same cycle.
//  N = 32 if is32 else XLEN. Latency accept->out_valid: 1 cycle for simple ops and shortcuts; N+1 for iterative ops.
//  Operands and op are latched at accept. Later changes on x/y/op do not affect the in-flight result.
//  Shifts: amount y[4:0] if is32 else y[$clog2(XLEN)-1:0]. srl in is32 shifts zero-extended x[31:0].
//      sra in is32 shifts sign-extended x[31:0].
//  slt/sltu/eq: result 0 or 1 (zero-extended); in is32 they compare the low 32 bits (signed/unsigned per op).
//  mul: low XLEN bits of product. mulh: high XLEN bits of the signed x signed 2*XLEN product.
//      In is32: bits [63:32] of the 64-bit product, sign-extended.
//  div/rem: signed, truncate toward zero; rem takes the sign of the dividend. Restoring division, 1 bit per cycle,
//      on magnitudes with a final sign fix.
//  Div by zero (1-cycle shortcut): div = all ones; rem = x (in is32, the sign-extended low 32 bits of x).
//  Overflow, most-negative / -1 (1-cycle shortcut): div = x; rem = 0.
//  op zero or not one-hot: result 0, 1-cycle latency, no error.
//  is32 result = {{32{r[31]}}, r[31:0]} for every op, including slt/eq.
//  kill with in_valid in the same cycle: kill wins, nothing accepted. Mid-op reset: async to IDLE, outputs to reset values.
// TESTING
//  1. Reset, add x=5 y=7 out_ready=1 -> out_valid one cycle after accept, result=12, in_ready=1 the next cycle.
//  2. is32 sra x=0x0000_0000_8000_0000 y=4 -> 0xFFFF_FFFF_F800_0000. 64-bit srl x=-1 y=63 -> 1.
//  3. 64-bit mul x=-3 y=7 (MUL_ITER=1) -> in_ready=0 for 64 cycles, out_valid at cycle 65, result=-21.
//     mulh x=2^62 y=4 -> 1.
//  4. div x=-7 y=2 -> -3; rem -> -1. div y=0 -> 0xFFFF_FFFF_FFFF_FFFF in 1 cycle. div x=0x8000_0000_0000_0000 y=-1 -> x.
//  5. Backpressure: out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0, a new in_valid is not accepted.
//  6. kill at BUSY cycle 20 of a div -> IDLE next cycle, out_valid never asserts. Next add issues normally.
//     Reset asserted mid-mul behaves the same.

Source files
------------

// File: rtl/alu_mdu_seq.sv
// Integer ALU with iterative signed multiply / mulh / div / rem behind a valid/ready handshake.
// Simple ops and division shortcuts complete in one cycle; iterative ops take N cycles in BUSY.
module alu_mdu_seq #(
  parameter int XLEN     = 64,
  parameter int OP_W     = 15,
  parameter int MUL_ITER = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic            is32,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  function automatic logic [XLEN-1:0] sx32(input logic [XLEN-1:0] v);
    sx32 = {XLEN{v[31]}};
    sx32[31:0] = v[31:0];
  endfunction

  function automatic logic [XLEN-1:0] fix32(input logic [XLEN-1:0] v, input logic w);
    fix32 = w ? sx32(v) : v;
  endfunction

  logic            accept, go_busy, onehot, div0, ovf, last;
  logic [XLEN-1:0] xs, ys, xz, yz, mx, my, simple_res;
  logic [SW-1:0]   sh;

  // Latched state of the in-flight iterative op
  logic              w_q, k_mulh, k_isdiv, k_rem, neg_q;
  logic [SW-1:0]     cnt;
  logic [2*XLEN-1:0] prod, mcand, prod_n, p_signed;
  logic [XLEN-1:0]   mplier, rem_r, quo, dvsr, rem_n, quo_n, div_mag, iter_raw;
  logic [XLEN:0]     div_sh, div_diff;
  logic              div_ge;

  assign accept = (state == IDLE) && in_valid && !kill;

  always_comb begin
    xs = is32 ? sx32(x) : x;
    ys = is32 ? sx32(y) : y;
    xz = '0;
    xz[31:0] = x[31:0];
    yz = '0;
    yz[31:0] = y[31:0];
    if (!is32) begin
      xz = x;
      yz = y;
    end
    mx = xs[XLEN-1] ? -xs : xs;
    my = ys[XLEN-1] ? -ys : ys;
    sh = is32 ? SW'(y[4:0]) : y[SW-1:0];
    onehot = (op != '0) && ((op & (op - 1'b1)) == '0);
    div0 = (ys == '0);
    ovf = is32 ? (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)
               : (x == {1'b1, {(XLEN-1){1'b0}}} && y == '1);
    go_busy = onehot && ((op[8] && (MUL_ITER != 0)) || op[9] ||
                         ((op[10] || op[11]) && !div0 && !ovf));
  end

  always_comb begin
    simple_res = '0;
    if (onehot) begin
      case (1'b1)
        op[0]:  simple_res = x + y;
        op[1]:  simple_res = x - y;
        op[2]:  simple_res = x & y;
        op[3]:  simple_res = x | y;
        op[4]:  simple_res = x ^ y;
        op[5]:  simple_res = x << sh;
        op[6]:  simple_res = xz >> sh;
        op[7]:  simple_res = $signed(xs) >>> sh;
        op[8]:  simple_res = (MUL_ITER == 0) ? x * y : '0;
        op[10]: simple_res = div0 ? '1 : xs;
        op[11]: simple_res = div0 ? xs : '0;
        op[12]: simple_res = {{(XLEN-1){1'b0}}, $signed(xs) < $signed(ys)};
        op[13]: simple_res = {{(XLEN-1){1'b0}}, xz < yz};
        op[14]: simple_res = {{(XLEN-1){1'b0}}, xz == yz};
        default: simple_res = '0;
      endcase
    end
  end

  // One shift-add step and one restoring-division step per BUSY cycle
  always_comb begin
    prod_n   = prod + (mplier[0] ? mcand : '0);
    p_signed = neg_q ? -prod_n : prod_n;
    div_sh   = {rem_r, quo[XLEN-1]};
    div_diff = div_sh - {1'b0, dvsr};
    div_ge   = !div_diff[XLEN];
    rem_n    = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
    quo_n    = {quo[XLEN-2:0], div_ge};
    div_mag  = k_rem ? rem_n : quo_n;
    if (k_isdiv)
      iter_raw = neg_q ? -div_mag : div_mag;
    else if (k_mulh)
      iter_raw = w_q ? p_signed[XLEN+31:32] : p_signed[2*XLEN-1:XLEN];
    else
      iter_raw = p_signed[XLEN-1:0];
    last = (cnt == (w_q ? SW'(31) : SW'(XLEN-1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = go_busy ? BUSY : DONE;
      BUSY:    if (kill) state_nxt = IDLE; else if (last) state_nxt = DONE;
      DONE:    if (kill || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == BUSY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result  <= '0;
      cnt     <= '0;
      w_q     <= 1'b0;
      k_mulh  <= 1'b0;
      k_isdiv <= 1'b0;
      k_rem   <= 1'b0;
      neg_q   <= 1'b0;
      prod    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem_r   <= '0;
      quo     <= '0;
      dvsr    <= '0;
    end else if (accept) begin
      cnt     <= '0;
      w_q     <= is32;
      k_mulh  <= op[9];
      k_isdiv <= op[10] || op[11];
      k_rem   <= op[11];
      neg_q   <= op[11] ? xs[XLEN-1] : (xs[XLEN-1] ^ ys[XLEN-1]);
      prod    <= '0;
      mcand   <= {{XLEN{1'b0}}, mx};
      mplier  <= my;
      rem_r   <= '0;
      quo     <= is32 ? (mx << 32) : mx;
      dvsr    <= my;
      if (!go_busy) result <= fix32(simple_res, is32);
    end else if (state == BUSY && !kill) begin
      cnt    <= cnt + 1'b1;
      prod   <= prod_n;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      rem_r  <= rem_n;
      quo    <= quo_n;
      if (last) result <= fix32(iter_raw, w_q);
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed self-checking bench for alu_mdu_seq (XLEN=64, iterative multiply).
module tb_alu_mdu_seq;

  localparam int XLEN = 64;
  localparam int OP_W = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, is32, kill, out_valid, out_ready, busy;
  logic [OP_W-1:0] op;
  logic [XLEN-1:0] x, y, result;

  int total = 0;
  int bad   = 0;

  alu_mdu_seq #(.XLEN(XLEN), .OP_W(OP_W), .MUL_ITER(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .is32(is32), .x(x), .y(y), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [OP_W-1:0] opc(input int i);
    return OP_W'(1) << i;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request for a single edge; returns 1 time unit after that edge
  task automatic applyStimulus(input logic [OP_W-1:0] o, input logic w,
                               input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1;
    op = o;
    is32 = w;
    x = a;
    y = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [OP_W-1:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_lat);
    int lat;
    applyStimulus(o, w, a, b);
    waitResult(lat);
    checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    checkOutput(tag, result, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic seen;
    rst = 1'b1;
    in_valid = 1'b0;
    kill = 1'b0;
    out_ready = 1'b1;
    op = '0;
    is32 = 1'b0;
    x = '0;
    y = '0;
    #12;
    $display("[TB] reset checks");
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] simple ops");
    runOp("add", opc(0), 0, 5, 7, 12, 1);
    checkOutput("add_ready_after", in_ready, 1);
    checkOutput("add_valid_after", out_valid, 0);
    runOp("sra32", opc(7), 1, 64'h0000_0000_8000_0000, 4, 64'hFFFF_FFFF_F800_0000, 1);
    runOp("srl64", opc(6), 0, 64'hFFFF_FFFF_FFFF_FFFF, 63, 1, 1);
    runOp("add32_wrap", opc(0), 1, 64'h7FFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000, 1);
    runOp("slt", opc(12), 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1);
    runOp("sltu", opc(13), 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1);
    runOp("eq32", opc(14), 1, 64'hAAAA_0000_1234_5678, 64'h1234_5678, 1, 1);
    runOp("not_onehot", 15'h0003, 0, 5, 7, 0, 1);

    $display("[TB] multiply / divide");
    runOp("mul", opc(8), 0, 64'hFFFF_FFFF_FFFF_FFFD, 7, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    runOp("mulh", opc(9), 0, 64'h4000_0000_0000_0000, 4, 1, 65);
    runOp("mul32", opc(8), 1, 64'h1_0000_0003, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 33);
    runOp("mulh32", opc(9), 1, 64'h4000_0000, 4, 1, 33);
    runOp("div", opc(10), 0, 64'hFFFF_FFFF_FFFF_FFF9, 2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    runOp("rem", opc(11), 0, 64'hFFFF_FFFF_FFFF_FFF9, 2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    runOp("div32", opc(10), 1, 64'hFFFF_FFF9, 2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    runOp("div_by0", opc(10), 0, 123, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    runOp("rem_by0", opc(11), 0, 42, 0, 42, 1);
    runOp("rem32_by0", opc(11), 1, 64'h1234_5678_9ABC_DEF0, 64'h1_0000_0000, 64'hFFFF_FFFF_9ABC_DEF0, 1);
    runOp("div_ovf", opc(10), 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    runOp("rem_ovf", opc(11), 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);

    $display("[TB] operands latched at accept");
    applyStimulus(opc(10), 0, 100, 7);
    op = opc(0);
    x = 5;
    y = 1;
    waitResult(lat);
    checkOutput("latch_lat", 64'(lat), 65);
    checkOutput("latch_res", result, 14);
    @(posedge clk);
    #1;

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(opc(0), 0, 1, 2);
    waitResult(lat);
    checkOutput("bp_lat", 64'(lat), 1);
    in_valid = 1'b1;
    op = opc(1);
    x = 100;
    y = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_res", result, 3);
      checkOutput("bp_ready", in_ready, 0);
    end
    checkOutput("bp_valid", out_valid, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", out_valid, 0);
    checkOutput("bp_release_ready", in_ready, 1);

    $display("[TB] kill mid-divide");
    applyStimulus(opc(10), 0, 1000, 3);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    checkOutput("kill_busy_before", busy, 1);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    checkOutput("kill_busy_after", busy, 0);
    checkOutput("kill_ready_after", in_ready, 1);
    checkOutput("kill_valid_after", out_valid, 0);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("kill_no_valid", seen, 0);
    runOp("add_after_kill", opc(0), 0, 2, 3, 5, 1);

    $display("[TB] kill with in_valid");
    in_valid = 1'b1;
    kill = 1'b1;
    op = opc(0);
    x = 9;
    y = 9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    kill = 1'b0;
    checkOutput("killacc_ready", in_ready, 1);
    checkOutput("killacc_valid", out_valid, 0);
    @(posedge clk);
    #1;
    checkOutput("killacc_valid2", out_valid, 0);

    $display("[TB] reset mid-multiply");
    applyStimulus(opc(8), 0, 64'hFFFF_FFFF_FFFF_FFFD, 7);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    checkOutput("mrst_busy_before", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mrst_ready", in_ready, 1);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_valid", out_valid, 0);
    checkOutput("mrst_result", result, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    runOp("add_after_rst", opc(0), 0, 4, 4, 8, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
